ram_access_ctrl: RTL and testbench

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

---
 rtl/ram_access_ctrl_if.sv | 42 ++++
 rtl/ram_access_ctrl.sv | 118 +++++++++++
 tb/tb_ram_access_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: burst request, write/read beat streams and the triple-port RAM pins.
// master = requester plus RAM side, slave = the controller.
interface ram_access_ctrl_if #(
    parameter int DATA_LEN    = 16,
    parameter int ADDRESS_LEN = 8,
    parameter int LEN_W       = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [3*ADDRESS_LEN-1:0] req_addr;
    logic [ADDRESS_LEN-1:0]   req_stride;
    logic [LEN_W-1:0]         req_len;
    logic                     wdata_valid;
    logic                     wdata_ready;
    logic [3*DATA_LEN-1:0]    wdata;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [3*DATA_LEN-1:0]    rsp_data;
    logic                     rsp_last;
    logic                     done;
    logic                     err_collide;
    logic                     ram_read;
    logic                     ram_write;
    logic [3*ADDRESS_LEN-1:0] ram_address;
    logic [3*DATA_LEN-1:0]    ram_data_in;
    logic [3*DATA_LEN-1:0]    ram_data_out;

    modport master (
        output req_valid, req_write, req_addr, req_stride, req_len, wdata_valid, wdata, rsp_ready,
               ram_data_out,
        input  req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, done, err_collide,
               ram_read, ram_write, ram_address, ram_data_in
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_stride, req_len, wdata_valid, wdata, rsp_ready,
               ram_data_out,
        output req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, done, err_collide,
               ram_read, ram_write, ram_address, ram_data_in
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: strided three-lane burst reader/writer for a triple-port RAM.
// Reads take issue/wait/hold per beat, writes take beat/commit per beat.
module ram_access_ctrl #(
    parameter int DATA_LEN    = 16,
    parameter int ADDRESS_LEN = 8,
    parameter int LEN_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_access_ctrl_if.slave  bus
);
    localparam int AW = 3 * ADDRESS_LEN;
    localparam int DW = 3 * DATA_LEN;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_HOLD, WR_BEAT, WR_COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d, addr_adv;
    logic [ADDRESS_LEN-1:0] stride_q, stride_d;
    logic [LEN_W-1:0]       len_q, len_d, cnt_q, cnt_d;
    logic [DW-1:0]          rsp_q, rsp_d, wbuf_q, wbuf_d;
    logic                   err_q, err_d, done_q, done_d;
    logic                   last, collide;
    logic [ADDRESS_LEN-1:0] a0, a1, a2;

    assign a0      = addr_q[0 +: ADDRESS_LEN];
    assign a1      = addr_q[ADDRESS_LEN +: ADDRESS_LEN];
    assign a2      = addr_q[2*ADDRESS_LEN +: ADDRESS_LEN];
    assign collide = (a0 == a1) || (a0 == a2) || (a1 == a2);
    assign last    = cnt_q == len_q;

    for (genvar i = 0; i < 3; i++) begin : g_adv
        assign addr_adv[i*ADDRESS_LEN +: ADDRESS_LEN] = addr_q[i*ADDRESS_LEN +: ADDRESS_LEN] + stride_q;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        rsp_d    = rsp_q;
        wbuf_d   = wbuf_q;
        err_d    = err_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                addr_d   = bus.req_addr;
                stride_d = bus.req_stride;
                len_d    = bus.req_len;
                cnt_d    = '0;
                err_d    = 1'b0;
                state_d  = bus.req_write ? WR_BEAT : RD_ISSUE;
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                rsp_d   = bus.ram_data_out;
                state_d = RD_HOLD;
            end
            RD_HOLD: if (bus.rsp_ready) begin
                done_d  = last;
                addr_d  = last ? addr_q : addr_adv;
                cnt_d   = last ? cnt_q : cnt_q + 1'b1;
                state_d = last ? IDLE : RD_ISSUE;
            end
            WR_BEAT: if (bus.wdata_valid) begin
                wbuf_d  = bus.wdata;
                state_d = WR_COMMIT;
            end
            WR_COMMIT: begin
                // the write still goes out on a collision; the RAM resolves it in favour of lane 2
                err_d   = err_q | collide;
                done_d  = last;
                addr_d  = last ? addr_q : addr_adv;
                cnt_d   = last ? cnt_q : cnt_q + 1'b1;
                state_d = last ? IDLE : WR_BEAT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            rsp_q    <= '0;
            wbuf_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            rsp_q    <= rsp_d;
            wbuf_q   <= wbuf_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // gated with rst_n so every output reads 0 while reset is held
    assign bus.req_ready   = rst_n && (state_q == IDLE);
    assign bus.wdata_ready = state_q == WR_BEAT;
    assign bus.rsp_valid   = state_q == RD_HOLD;
    assign bus.rsp_last    = (state_q == RD_HOLD) && last;
    assign bus.rsp_data    = rsp_q;
    assign bus.done        = done_q;
    assign bus.err_collide = err_q;
    assign bus.ram_read    = state_q == RD_ISSUE;
    assign bus.ram_write   = state_q == WR_COMMIT;
    assign bus.ram_address = addr_q;
    assign bus.ram_data_in = wbuf_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed table, random bursts and reset/backpressure sequences
// checked against a shadow-memory model of strided three-lane bursts.
module tb_ram_access_ctrl;
    localparam int DL = 16;
    localparam int AL = 8;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_access_ctrl_if #(.DATA_LEN(DL), .ADDRESS_LEN(AL), .LEN_W(LW)) bus();
    ram_access_ctrl #(.DATA_LEN(DL), .ADDRESS_LEN(AL), .LEN_W(LW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    function automatic logic [DL-1:0] fill_val(input int i);
        return DL'(i * 40503 + 7);
    endfunction

    logic [DL-1:0] mem [256];
    logic [DL-1:0] exp_mem [256];
    logic          filled = 1'b0;

    // triple-port RAM: lanes written in order so lane 2 wins a shared address
    always @(posedge clk) begin
        if (!rst_n && !filled) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill_val(i);
            filled <= 1'b1;
        end else if (bus.ram_write) begin
            for (int i = 0; i < 3; i++) mem[bus.ram_address[i*AL +: AL]] <= bus.ram_data_in[i*DL +: DL];
        end
        if (bus.ram_read)
            for (int i = 0; i < 3; i++) bus.ram_data_out[i*DL +: DL] <= mem[bus.ram_address[i*AL +: AL]];
    end

    logic [3*AL+3*DL-1:0] wr_log [$];
    logic [3*AL-1:0]      rd_log [$];
    int                   both_cnt = 0;

    always @(negedge clk) begin
        if (bus.ram_write) wr_log.push_back({bus.ram_address, bus.ram_data_in});
        if (bus.ram_read) rd_log.push_back(bus.ram_address);
        if (bus.ram_read && bus.ram_write) both_cnt++;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // want_err < 0 takes the collision flag from the model; exp_cyc < 0 skips the timing check
    task automatic run_burst(input logic w, input logic [3*AL-1:0] a, input logic [AL-1:0] s,
                             input logic [LW-1:0] l, input bit stall, input int hold0,
                             input int exp_cyc, input int want_err);
        logic [3*DL-1:0] beat_d [16];
        logic [3*AL-1:0] beat_a [16];
        logic [3*DL-1:0] exp_r [16];
        logic            m_err, e_err;
        logic [AL-1:0]   x0, x1, x2;
        int              nb, wr0, rd0, k, held, cyc;
        nb = int'(l) + 1;
        m_err = 1'b0;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 3; i++) beat_a[b][i*AL +: AL] = AL'(int'(a[i*AL +: AL]) + b * int'(s));
            x0 = beat_a[b][0 +: AL];
            x1 = beat_a[b][AL +: AL];
            x2 = beat_a[b][2*AL +: AL];
            if (w && (x0 == x1 || x0 == x2 || x1 == x2)) m_err = 1'b1;
            beat_d[b] = (3*DL)'({$urandom(), $urandom()});
            for (int i = 0; i < 3; i++) exp_r[b][i*DL +: DL] = exp_mem[beat_a[b][i*AL +: AL]];
            if (w) for (int i = 0; i < 3; i++) exp_mem[beat_a[b][i*AL +: AL]] = beat_d[b][i*DL +: DL];
        end
        e_err = (want_err < 0) ? m_err : (want_err != 0);
        for (int t = 0; t < 20 && !bus.req_ready; t++) @(negedge clk);
        wr0 = wr_log.size();
        rd0 = rd_log.size();
        bus.req_valid   = 1'b1;
        bus.req_write   = w;
        bus.req_addr    = a;
        bus.req_stride  = s;
        bus.req_len     = l;
        bus.wdata_valid = w && !stall;
        bus.wdata       = beat_d[0];
        bus.rsp_ready   = 1'b0;
        k = 0;
        held = 0;
        cyc = 0;
        for (int c = 1; c <= 400 && cyc == 0; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.done) cyc = c;
            else if (w && bus.wdata_ready && k < nb) begin
                if (stall && $urandom_range(0, 2) == 0) bus.wdata_valid = 1'b0;
                else begin
                    bus.wdata_valid = 1'b1;
                    bus.wdata = beat_d[k];
                    k++;
                end
            end else if (!w && bus.rsp_valid && k < nb) begin
                chk("rsp_data", 72'(bus.rsp_data), 72'(exp_r[k]));
                chk("rsp_last", 72'(bus.rsp_last), 72'(k == nb - 1));
                chk("reads_issued", 72'(rd_log.size() - rd0), 72'(k + 1));
                if ((k == 0 && held < hold0) || (stall && $urandom_range(0, 2) == 0)) begin
                    bus.rsp_ready = 1'b0;
                    held++;
                end else begin
                    bus.rsp_ready = 1'b1;
                    k++;
                end
            end
        end
        chk("done_seen", 72'(cyc != 0), 72'(1));
        if (cyc != 0) begin
            if (exp_cyc >= 0) chk("burst_cycles", 72'(cyc), 72'(exp_cyc));
            chk("req_ready_at_done", 72'(bus.req_ready), 72'(1));
            chk("err_collide", 72'(bus.err_collide), 72'(e_err));
            chk("beats", 72'(k), 72'(nb));
            chk("ram_writes", 72'(wr_log.size() - wr0), 72'(w ? nb : 0));
            chk("ram_reads", 72'(rd_log.size() - rd0), 72'(w ? 0 : nb));
            for (int b = 0; b < nb; b++) begin
                if (w && wr0 + b < wr_log.size()) chk("wr_event", 72'(wr_log[wr0 + b]), 72'({beat_a[b], beat_d[b]}));
                if (!w && rd0 + b < rd_log.size()) chk("rd_addr", 72'(rd_log[rd0 + b]), 72'(beat_a[b]));
            end
            chk("read_write_overlap", 72'(both_cnt), 72'(0));
            @(negedge clk);
            chk("done_width", 72'(bus.done), 72'(0));
            chk("err_sticky", 72'(bus.err_collide), 72'(e_err));
        end
        bus.wdata_valid = 1'b0;
        bus.rsp_ready   = 1'b0;
    endtask

    typedef struct {
        logic             w;
        logic [3*AL-1:0]  a;
        logic [AL-1:0]    s;
        logic [LW-1:0]    l;
        int               err;
        int               cyc;
    } vec_t;

    vec_t            tbl [8];
    logic            rw, narrow, stl, hit;
    logic [3*AL-1:0] ra;
    logic [AL-1:0]   rs;
    logic [LW-1:0]   rl;
    int              rd0, wr0, dn, kk;

    initial begin
        tbl[0] = '{1'b1, {8'h62, 8'h61, 8'h60}, 8'h03, 4'd3,  0, 9};
        tbl[1] = '{1'b0, {8'h3E, 8'h3F, 8'h40}, 8'h01, 4'd0,  0, 4};
        tbl[2] = '{1'b1, {8'h01, 8'h00, 8'hF8}, 8'h10, 4'd1,  0, 5};
        tbl[3] = '{1'b1, {8'h07, 8'h05, 8'h05}, 8'h01, 4'd0,  1, 3};
        tbl[4] = '{1'b0, {8'h62, 8'h61, 8'h60}, 8'h03, 4'd3,  0, 13};
        tbl[5] = '{1'b0, {8'h20, 8'h10, 8'hFE}, 8'h01, 4'd15, 0, 49};
        tbl[6] = '{1'b1, {8'h33, 8'h34, 8'h33}, 8'h02, 4'd2,  1, 7};
        tbl[7] = '{1'b1, {8'h82, 8'h81, 8'h80}, 8'hFF, 4'd2,  0, 7};
        for (int i = 0; i < 256; i++) exp_mem[i] = fill_val(i);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr = '0;
        bus.req_stride = '0;
        bus.req_len = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 72'(bus.req_ready), 72'(0));
        chk("rst_flags", 72'({bus.rsp_valid, bus.rsp_last, bus.wdata_ready, bus.done,
                              bus.err_collide, bus.ram_read, bus.ram_write}), 72'(0));
        chk("rst_ram_address", 72'(bus.ram_address), 72'(0));
        chk("rst_data", 72'({bus.rsp_data, bus.ram_data_in}), 72'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", 72'(bus.req_ready), 72'(1));

        for (int v = 0; v < 8; v++)
            run_burst(tbl[v].w, tbl[v].a, tbl[v].s, tbl[v].l, 1'b0, 0, tbl[v].cyc, tbl[v].err);

        // read held off for five cycles on beat 0
        run_burst(1'b0, {8'h12, 8'h11, 8'h10}, 8'h04, 4'd1, 1'b0, 5, 12, 0);

        // reset while beat 1 of a four-beat read sits in RD_HOLD
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr = {8'h52, 8'h51, 8'h50};
        bus.req_stride = 8'h01;
        bus.req_len = 4'd3;
        bus.rsp_ready = 1'b0;
        kk = 0;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                if (kk == 1) hit = 1'b1;
                else begin
                    bus.rsp_ready = 1'b1;
                    kk++;
                end
            end
        end
        chk("abort_point_reached", 72'(hit), 72'(1));
        bus.rsp_ready = 1'b0;
        rd0 = rd_log.size();
        wr0 = wr_log.size();
        rst_n = 1'b0;
        #1;
        chk("abort_flags", 72'({bus.req_ready, bus.rsp_valid, bus.rsp_last, bus.wdata_ready,
                                bus.done, bus.ram_read, bus.ram_write}), 72'(0));
        chk("abort_data", 72'(bus.rsp_data), 72'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            dn += int'(bus.done);
        end
        chk("abort_no_done", 72'(dn), 72'(0));
        chk("abort_no_access", 72'(rd_log.size() + wr_log.size() - rd0 - wr0), 72'(0));
        chk("abort_req_ready", 72'(bus.req_ready), 72'(1));
        run_burst(1'b0, {8'h52, 8'h51, 8'h50}, 8'h01, 4'd3, 1'b0, 0, 13, 0);

        for (int r = 0; r < 40; r++) begin
            rw = 1'($urandom_range(0, 1));
            narrow = 1'($urandom_range(0, 1));
            stl = 1'($urandom_range(0, 1));
            for (int i = 0; i < 3; i++) ra[i*AL +: AL] = AL'(narrow ? $urandom_range(0, 3) : $urandom_range(0, 255));
            rs = AL'($urandom_range(0, 255));
            rl = LW'($urandom_range(0, 15));
            run_burst(rw, ra, rs, rl, stl, 0, stl ? -1 : (rw ? 2 : 3) * (int'(rl) + 1) + 1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
